// File: rtl/mips_mem_pkg.sv
// Shared instruction-memory geometry and loader state encoding.
// Also imported by the instruction memory, so both agree on the depth.
package mips_mem_pkg;

    localparam int NB_DATA    = 32;
    localparam int NBYTE      = 8;
    localparam int N_ELEMENTS = 128;
    localparam int ADDRWIDTH  = $clog2(N_ELEMENTS);

    localparam logic [NB_DATA-1:0]   HALT_WORD  = 32'hFFFF_FFFF;
    localparam logic [ADDRWIDTH:0]   WORD_LIMIT = (ADDRWIDTH+1)'(N_ELEMENTS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } load_state_e;

endpackage

// File: rtl/byte_packer.sv
// Packs incoming bytes little-endian into a word; flags the 4th byte.
// word_o already contains the byte being accepted so the caller can latch it directly.
module byte_packer
    import mips_mem_pkg::*;
(
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               byte_valid_i,
    input  logic [NBYTE-1:0]   byte_i,
    output logic               word_valid_o,
    output logic [NB_DATA-1:0] word_o
);

    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [NB_DATA-1:0] word_q,     word_d;

    // Lane update: the current byte lands at lane byte_idx, index wraps after lane 3.
    always_comb begin
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
        word_valid_o = 1'b0;
        if (clear_i) begin
            byte_idx_d = 2'd0;
            word_d     = {NB_DATA{1'b0}};
        end else if (byte_valid_i) begin
            word_d[{byte_idx_q, 3'b000} +: NBYTE] = byte_i;
            byte_idx_d   = byte_idx_q + 2'd1;
            word_valid_o = (byte_idx_q == 2'd3);
        end else begin
            byte_idx_d = byte_idx_q;
        end
        word_o = word_d;
    end

    // Lane index and partial-word register.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            byte_idx_q <= 2'd0;
            word_q     <= {NB_DATA{1'b0}};
        end else begin
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
        end
    end

endmodule

// File: rtl/inst_loader.sv
// Program loader: packs UART bytes into words and writes them to instruction memory
// from address 0 until the HALT word is stored or the memory is full.
module inst_loader
    import mips_mem_pkg::*;
(
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic [NBYTE-1:0]     rx_data_i,
    input  logic                 rx_valid_i,
    output logic                 mem_en_write_o,
    output logic [ADDRWIDTH-1:0] mem_addr_o,
    output logic [NB_DATA-1:0]   mem_data_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 overflow_o,
    output logic [ADDRWIDTH:0]   word_count_o
);

    load_state_e          state_q, state_d;
    logic [ADDRWIDTH:0]   word_count_q, word_count_d;
    logic [ADDRWIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [NB_DATA-1:0]   mem_data_q, mem_data_d;
    logic                 mem_en_write_q, mem_en_write_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 overflow_q, overflow_d;

    logic                 start_load_s;
    logic                 accept_s;
    logic                 word_valid_s;
    logic [NB_DATA-1:0]   word_s;

    byte_packer u_byte_packer (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .clear_i      (start_load_s),
        .byte_valid_i (accept_s),
        .byte_i       (rx_data_i),
        .word_valid_o (word_valid_s),
        .word_o       (word_s)
    );

    // Next-state logic; status outputs are decoded from the next state so they are registered.
    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        start_load_s = 1'b0;
        accept_s     = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_i) begin
                    start_load_s = 1'b1;
                    word_count_d = {(ADDRWIDTH+1){1'b0}};
                    state_d      = ST_RECV;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RECV, ST_WRITE: begin
                accept_s = rx_valid_i;
                if (state_q == ST_WRITE) begin
                    state_d = (mem_data_q == HALT_WORD) ? ST_DONE : ST_RECV;
                end else begin
                    state_d = ST_RECV;
                end
                // A byte taken during WRITE is lane 0, so a word never completes in WRITE.
                if (word_valid_s) begin
                    if (word_count_q == WORD_LIMIT) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d      = ST_WRITE;
                        mem_addr_d   = word_count_q[ADDRWIDTH-1:0];
                        mem_data_d   = word_s;
                        word_count_d = word_count_q + {{ADDRWIDTH{1'b0}}, 1'b1};
                    end
                end else begin
                    word_count_d = word_count_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        mem_en_write_d = (state_d == ST_WRITE);
        busy_d         = (state_d == ST_RECV) || (state_d == ST_WRITE);
        done_d         = (state_d == ST_DONE);
        overflow_d     = (state_d == ST_ERROR);
    end

    // State, counter and output registers; reset discards any pending write.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q        <= ST_IDLE;
            word_count_q   <= {(ADDRWIDTH+1){1'b0}};
            mem_addr_q     <= {ADDRWIDTH{1'b0}};
            mem_data_q     <= {NB_DATA{1'b0}};
            mem_en_write_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            word_count_q   <= word_count_d;
            mem_addr_q     <= mem_addr_d;
            mem_data_q     <= mem_data_d;
            mem_en_write_q <= mem_en_write_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            overflow_q     <= overflow_d;
        end
    end

    assign mem_en_write_o = mem_en_write_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_data_o     = mem_data_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign overflow_o     = overflow_q;
    assign word_count_o   = word_count_q;

endmodule

// File: doc/inst_loader.md
# inst_loader

Program loader placed directly upstream of the instruction memory in the MIPS pipeline. Takes a byte stream from the UART receiver and packs every four bytes into a little-endian 32-bit instruction. Writes each word into consecutive instruction-memory addresses starting at 0. Stops on the HALT word or on memory overflow and reports status to the debug unit.

## Interface
- NB_DATA, 32, instruction word width
- NBYTE, 8, byte width of the incoming stream
- N_ELEMENTS, 128, instruction-memory depth in words; ADDRWIDTH = $clog2(N_ELEMENTS)
- HALT_WORD, 32'hFFFF_FFFF, end-of-program instruction

Ports:
- clock_i  in  1  single system clock, all logic on posedge
- reset_i  in  1  synchronous, active-high reset
- start_i  in  1  level/pulse; arms a new load (sampled in IDLE, DONE, ERROR)
- rx_data_i  in  NBYTE  received byte
- rx_valid_i  in  1  one-cycle strobe, rx_data_i valid
- mem_en_write_o  out  1  write strobe to instruction memory, one cycle per word
- mem_addr_o  out  ADDRWIDTH  word address of the write
- mem_data_o  out  NB_DATA  packed instruction
- busy_o  out  1  high in RECV and WRITE
- done_o  out  1  high in DONE (HALT word stored)
- overflow_o  out  1  high in ERROR
- word_count_o  out  ADDRWIDTH+1  number of words written in current load

## Operation
- States: IDLE, RECV, WRITE, DONE, ERROR.
- IDLE: ignore rx_valid_i. start_i=1 -> clear word_count and byte index -> RECV.
- RECV: each rx_valid_i stores rx_data_i into byte lane byte_idx. Byte 0 goes to [7:0], byte 3 to [31:24]. byte_idx is 2 bits and increments per byte.
- On the 4th byte (byte_idx=3 with rx_valid_i):
  - word_count == N_ELEMENTS -> ERROR, no write.
  - otherwise -> WRITE; word latched into mem_data_o, mem_addr_o = word_count[ADDRWIDTH-1:0].
- WRITE (exactly one cycle): mem_en_write_o=1, word_count increments.
  - Stored word == HALT_WORD -> DONE.
  - Otherwise -> RECV.
  - A rx_valid_i arriving in WRITE is accepted as byte 0 of the next word; bytes are never dropped.
- DONE / ERROR: hold status. rx_valid_i ignored. start_i=1 -> new load as from IDLE; memory is overwritten from address 0.
- HALT_WORD is written to memory before DONE, so the pipeline fetches it.
- Memory contents are never cleared by this block.

## Timing
- All outputs are registered. Reset values:
  - state IDLE
  - mem_en_write_o=0, mem_addr_o=0, mem_data_o=0
  - busy_o=0, done_o=0, overflow_o=0, word_count_o=0
- Latency: mem_en_write_o is high in the cycle after the clock edge that samples the 4th rx_valid_i. Minimum spacing between writes is 4 cycles (back-to-back bytes).
- mem_addr_o and mem_data_o are stable throughout the write cycle and hold their value afterwards.
- done_o and overflow_o rise in the cycle after the terminating event and stay high until start_i or reset_i.
- reset_i mid-word or mid-write has priority over everything:
  - next cycle is IDLE
  - partial bytes discarded
  - any pending write suppressed
- start_i while busy_o=1 is ignored.
- Overflow boundary: exactly N_ELEMENTS words without HALT leaves word_count_o=128 in RECV. A further complete word goes to ERROR with no write.

## Structure
- Shared package/header `mips_mem_pkg`: N_ELEMENTS, ADDRWIDTH, NB_DATA, NBYTE, HALT_WORD, and state encoding localparams. The instruction memory uses the same package for its depth.
- One natural sub-module: `byte_packer`. It holds the 2-bit lane index and the 32-bit shift/lane register, and emits word_valid on the 4th byte. The FSM, address counter and status flags stay in inst_loader.

## Test plan
- Reset then start_i, bytes 0x13,0x00,0x01,0x20 -> one write cycle later: addr 0, data 0x2001_0013, word_count_o=1, busy_o=1.
- Three words then FF,FF,FF,FF -> writes at addr 0..3, addr 3 data 0xFFFF_FFFF, done_o=1 next cycle, busy_o=0.
- 129 non-HALT words -> 128 writes (addr 0..127), no 129th write, overflow_o=1, word_count_o=128.
- Bytes back-to-back every cycle, including one during WRITE -> no byte lost; words written every 4 cycles in the correct order.
- reset_i after 2 bytes, then start_i and 4 new bytes -> only the new word is written, at addr 0; old bytes absent from the data.
- start_i while busy and rx_valid_i while IDLE -> no state change; no write.
